// File: rtl/cmp_sched_pkg.sv
// cmp_sched_pkg: shared state encoding, response codes and timeout default
package cmp_sched_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_VALID, S_DONE} state_t;
  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_NEG  = 2'b01;
  localparam logic [1:0] CODE_POS  = 2'b10;
  localparam logic [1:0] CODE_TMO  = 2'b11;
  localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/cmp_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at the pointer index
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int o = 0; o < N_REQ; o++) begin
      automatic int k = (int'(i_ptr) + o) % N_REQ;
      if (!o_any && i_req[k]) begin
        o_gnt[k] = 1'b1;
        o_idx = IW'(k);
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cmp_sched.sv
// cmp_sched: round-robin scheduler sharing one compare unit among N_REQ requesters
module cmp_sched
  import cmp_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     gnt,
  output logic                 resp_valid,
  output logic [1:0]           resp_id,
  output logic [1:0]           resp_code,
  output logic                 busy,
  output logic                 cmp_start,
  output logic [7:0]           cmp_data,
  input  logic                 cmp_rdy,
  input  logic [7:0]           cmp_result
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t r_state, w_state_n;
  logic [IW-1:0] r_idx, w_idx_n, r_ptr, w_ptr_n, w_arb_idx;
  logic [N_REQ-1:0] r_gnt, w_gnt_n, w_arb_gnt;
  logic [7:0] r_op, w_op_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [1:0] r_code, w_code_n;
  logic w_any;
  logic w_unused;

  assign w_unused = ^cmp_result[7:2];

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .i_req(req),
    .i_ptr(r_ptr),
    .o_gnt(w_arb_gnt),
    .o_idx(w_arb_idx),
    .o_any(w_any)
  );

  always_comb begin
    w_state_n = r_state;
    w_idx_n = r_idx;
    w_ptr_n = r_ptr;
    w_gnt_n = r_gnt;
    w_op_n = r_op;
    w_cnt_n = r_cnt;
    w_code_n = r_code;
    case (r_state)
      S_IDLE: if (w_any) begin
        w_state_n = S_ISSUE;
        w_idx_n = w_arb_idx;
        w_gnt_n = w_arb_gnt;
        w_op_n = req_data[8*w_arb_idx +: 8];
        w_ptr_n = (w_arb_idx == IW'(N_REQ - 1)) ? '0 : w_arb_idx + 1'b1;
      end
      S_ISSUE: begin
        w_cnt_n = '0;
        w_state_n = S_WAIT;
      end
      S_WAIT: begin
        w_cnt_n = r_cnt + 1'b1;
        if (cmp_rdy) w_state_n = S_VALID;
        else if (r_cnt == CW'(TIMEOUT)) begin
          w_code_n = CODE_TMO;
          w_state_n = S_DONE;
        end
      end
      S_VALID: begin
        w_code_n = cmp_result[1:0];
        w_state_n = S_DONE;
      end
      S_DONE: begin
        w_gnt_n = '0;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx <= '0;
      r_ptr <= '0;
      r_gnt <= '0;
      r_op <= '0;
      r_cnt <= '0;
      r_code <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx <= w_idx_n;
      r_ptr <= w_ptr_n;
      r_gnt <= w_gnt_n;
      r_op <= w_op_n;
      r_cnt <= w_cnt_n;
      r_code <= w_code_n;
    end
  end

  assign gnt = r_gnt;
  assign busy = r_state != S_IDLE;
  assign cmp_start = r_state == S_ISSUE;
  assign cmp_data = (r_state inside {S_ISSUE, S_WAIT, S_VALID}) ? r_op : '0;
  assign resp_valid = r_state == S_DONE;
  assign resp_id = resp_valid ? 2'(r_idx) : '0;
  assign resp_code = resp_valid ? r_code : '0;
endmodule

// File: doc/cmp_sched.md
CMP_SCHED -- requirements
Module: cmp_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one compare unit.
REQ-002 Parameter TIMEOUT, default 15, maximum WAIT cycles before abort.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req  input  N_REQ  per-requester request level.
REQ-006 req_data  input  8*N_REQ  packed signed operands; requester i owns bits [8i+7:8i].
REQ-007 gnt  output  N_REQ  one-hot grant, held for the whole transaction.
REQ-008 resp_valid  output  1  one-cycle response strobe.
REQ-009 resp_id  output  2  index of the requester being answered.
REQ-010 resp_code  output  2  01 negative, 10 positive, 00 zero, 11 timeout.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 cmp_start  output  1  one-cycle start pulse to the compare unit.
REQ-013 cmp_data  output  8  operand to the compare unit.
REQ-014 cmp_rdy  input  1  compare unit output-ready.
REQ-015 cmp_result  input  8  compare unit result; only [1:0] is meaningful.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, VALID and DONE.
REQ-017 IDLE: if any req is high, the round-robin winner SHALL be chosen, its req_data latched, its gnt set, and the FSM SHALL go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-018 Round-robin search SHALL start at index (last_granted+1) mod N_REQ; after reset the pointer SHALL select index 0 first.
REQ-019 ISSUE: cmp_start=1 for exactly one cycle, timeout counter cleared, next state WAIT.
REQ-020 cmp_data SHALL drive the latched operand from ISSUE through VALID and SHALL be 0 otherwise.
REQ-021 WAIT: counter increments each cycle; cmp_rdy=1 goes to VALID; counter==TIMEOUT with cmp_rdy=0 loads code 11 and goes to DONE.
REQ-022 VALID: lasts one cycle; cmp_result[1:0] SHALL be captured at the end of this cycle, the second consecutive cycle with cmp_rdy high; next state DONE.
REQ-023 DONE: resp_valid=1, resp_id=granted index, resp_code=captured code, gnt cleared on exit; next state IDLE.
REQ-024 Latency SHALL be 6 cycles from the edge that samples req in IDLE to the cycle in which resp_valid is high, against a nominal compare unit.
REQ-025 If req drops mid-transaction, the transaction SHALL complete and resp_valid SHALL still be issued.
REQ-026 A req held high after its response SHALL be treated as a new request, subject to round-robin order.
REQ-027 cmp_start SHALL never be asserted while busy is high outside ISSUE.
REQ-028 resp_id and resp_code SHALL be 0 whenever resp_valid is 0.

Reset
REQ-029 With rst high at a clock edge, the block SHALL enter IDLE with gnt, resp_valid, resp_id, resp_code, busy, cmp_start, cmp_data, the counter and the RR pointer at 0.
REQ-030 Reset mid-transaction SHALL abort with no resp_valid; the compare unit shares the same rst.

Structure
REQ-031 A shared package SHALL hold the state encoding, the result codes (00/01/10/11) and the TIMEOUT default.
REQ-032 A sub-module rr_arbiter (N_REQ requests plus pointer in, one-hot grant and index out, combinational) SHALL implement the round-robin selection; the FSM stays in cmp_sched.

Verification
REQ-033 req=0001, op0=+5 -> gnt=0001, one cmp_start pulse, cmp_data=05 held 4 cycles, resp_valid after 6 cycles, id=0, code=10.
REQ-034 op=-3 (FD), then op=0 on requester 2 -> codes 01 and 00, ids 0 and 2.
REQ-035 req=1111 held continuously -> grants in order 0,1,2,3,0; each answered once per round.
REQ-036 Compare-unit model never raises cmp_rdy -> resp_code=11 after TIMEOUT WAIT cycles; FSM returns to IDLE.
REQ-037 rst pulsed during WAIT -> outputs 0 next cycle, no resp_valid; the next request is served from index 0.
REQ-038 req1 dropped one cycle after grant -> response still issued with id=1.
